// File: rtl/mem_access_ctrl.sv
//------------------------------------------------------------------------------
// Module   : mem_access_ctrl
// Purpose  : Arbitrates instruction fetches and data accesses onto a single
//            unified memory port. A three-state FSM (IDLE/ACCESS/RESP) holds
//            the access on the memory port for LATENCY cycles, captures the
//            read data on the last ACCESS cycle and pulses a one-cycle ack.
//            Data requests win over fetch requests. The losing request is
//            served after the current access completes.
// Macro    : MEM_ALIGN_CHECK_EN - when defined, a fetch with if_pc[1:0] != 0
//            skips the memory and answers with if_ack + err in one cycle.
//            When undefined, every fetch is performed and err is tied low.
// Ports    : clk, rst_n (async, active-low)
//            if_req/if_pc  -> if_ack, ir       instruction fetch side
//            d_req/d_we/d_addr/d_wdata -> d_ack, mdr   data side
//            busy, err                          status
//            mem_addr/mem_wdata/mem_write <- mem_rdata  unified memory port
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_ctrl #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    output logic        if_ack,
    output logic [31:0] ir,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] mdr,
    output logic        busy,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] C_CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       is_data_q;

`ifndef MEM_ALIGN_CHECK_EN
    assign err = 1'b0;
`endif

    // The memory-port registers double as the latched request: they are
    // loaded on acceptance and cleared when ACCESS ends, so they read 0 in
    // IDLE and RESP without any extra decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            is_data_q <= 1'b0;
            ir        <= 32'd0;
            mdr       <= 32'd0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_write <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            err       <= 1'b0;
`endif
        end else begin
            // Acks and err are single-cycle pulses unless re-asserted below.
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            err    <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (d_req) begin
                        state_q   <= S_ACCESS;
                        busy      <= 1'b1;
                        cnt_q     <= C_CNT_LOAD;
                        is_data_q <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_write <= d_we;
                    end else if (if_req) begin
                        busy      <= 1'b1;
                        is_data_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                        if (if_pc[1:0] != 2'b00) begin
                            // Misaligned fetch: answer immediately, memory untouched.
                            state_q <= S_RESP;
                            if_ack  <= 1'b1;
                            err     <= 1'b1;
                        end else
`endif
                        begin
                            state_q   <= S_ACCESS;
                            cnt_q     <= C_CNT_LOAD;
                            mem_addr  <= if_pc;
                            mem_wdata <= 32'd0;
                            mem_write <= 1'b0;
                        end
                    end
                end

                S_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        state_q   <= S_RESP;
                        mem_addr  <= 32'd0;
                        mem_wdata <= 32'd0;
                        mem_write <= 1'b0;
                        if (is_data_q) begin
                            d_ack <= 1'b1;
                            // mem_write still reflects the access type here;
                            // writes must not disturb mdr.
                            if (!mem_write) begin
                                mdr <= mem_rdata;
                            end
                        end else begin
                            if_ack <= 1'b1;
                            ir     <= mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                S_RESP: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    state_q   <= S_IDLE;
                    busy      <= 1'b0;
                    mem_addr  <= 32'd0;
                    mem_wdata <= 32'd0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl. A transaction-level
//            model predicts every output each cycle for the LATENCY=1
//            instance; directed literal checks pin key cycles, and a second
//            LATENCY=3 instance is checked with literal expectations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_ctrl;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we;
    logic [31:0] if_pc, d_addr, d_wdata;
    logic        if_ack, d_ack, busy, err, mem_write;
    logic [31:0] ir, mdr, mem_addr, mem_wdata, mem_rdata;

    logic        d3_req, d3_we;
    logic [31:0] d3_addr, d3_wdata;
    logic        if3_ack, d3_ack, busy3, err3, mem3_write;
    logic [31:0] ir3, mdr3, mem3_addr, mem3_wdata, mem3_rdata;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_pc(if_pc), .if_ack(if_ack), .ir(ir),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .mdr(mdr), .busy(busy), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    mem_access_ctrl #(.LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .if_req(1'b0), .if_pc(32'd0), .if_ack(if3_ack), .ir(ir3),
        .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
        .d_ack(d3_ack), .mdr(mdr3), .busy(busy3), .err(err3),
        .mem_addr(mem3_addr), .mem_wdata(mem3_wdata), .mem_write(mem3_write),
        .mem_rdata(mem3_rdata)
    );

    // Unified memory seen by the LATENCY=1 instance.
    logic [31:0] mem [256];
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;

    // Address-tagged read data for the LATENCY=3 instance.
    assign mem3_rdata = {16'hA5A5, mem3_addr[15:0]};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    int unsigned t = 0, acc_t = 0;
    logic        m_act = 1'b0, m_data = 1'b0, m_we = 1'b0, m_mis = 1'b0;
    logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;
    logic [31:0] exp_ir = 32'd0, exp_mdr = 32'd0;
    logic [31:0] shadow [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            shadow[i] = 32'h1000_0000 + 32'(i);
            mem[i]    = 32'h1000_0000 + 32'(i);
        end
        shadow[128] = 32'h8c03_0000; mem[128] = 32'h8c03_0000;
        shadow[0]   = 32'd8;         mem[0]   = 32'd8;
        shadow[130] = 32'hdead_beef; mem[130] = 32'hdead_beef;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                t = 0; m_act = 1'b0; exp_ir = 32'd0; exp_mdr = 32'd0;
            end else begin
                t++;
                // Transaction accepted at edge A completes its data phase at A+LAT.
                if (m_act && !m_mis && t == acc_t + LAT) begin
                    if (!m_data)   exp_ir = shadow[m_addr[7:0]];
                    else if (m_we) shadow[m_addr[7:0]] = m_wdata;
                    else           exp_mdr = shadow[m_addr[7:0]];
                end
                // Normal access is over (idle again) at A+LAT+1; misaligned at A+1.
                if (m_act && t >= acc_t + (m_mis ? 2 : LAT + 2)) m_act = 1'b0;
                if (!m_act && (d_req || if_req)) begin
                    m_act = 1'b1; acc_t = t; m_data = d_req; m_mis = 1'b0;
                    if (d_req) begin
                        m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                    end else begin
                        m_we = 1'b0; m_addr = if_pc; m_wdata = 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
                        m_mis = (if_pc[1:0] != 2'b00);
`endif
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        e_ifack, e_dack, e_busy, e_err, e_mw;
    logic [31:0] e_ma, e_mwd;
    int unsigned k;

    always @(negedge clk) begin
        e_ifack = 0; e_dack = 0; e_busy = 0; e_err = 0; e_mw = 0;
        e_ma = 32'd0; e_mwd = 32'd0; k = 0;
        if (rst_n && m_act) begin
            k = t - acc_t;
            if (m_mis) begin
                if (k == 0) begin e_ifack = 1; e_err = 1; e_busy = 1; end
            end else if (k < LAT) begin
                e_busy = 1; e_ma = m_addr; e_mwd = m_wdata; e_mw = m_data && m_we;
            end else if (k == LAT) begin
                e_busy = 1;
                if (m_data) e_dack = 1; else e_ifack = 1;
            end
        end
        chk("cyc_if_ack",    32'(if_ack),    32'(e_ifack));
        chk("cyc_d_ack",     32'(d_ack),     32'(e_dack));
        chk("cyc_busy",      32'(busy),      32'(e_busy));
        chk("cyc_err",       32'(err),       32'(e_err));
        chk("cyc_mem_write", 32'(mem_write), 32'(e_mw));
        chk("cyc_mem_addr",  mem_addr,       e_ma);
        chk("cyc_mem_wdata", mem_wdata,      e_mwd);
        chk("cyc_ir",        ir,             exp_ir);
        chk("cyc_mdr",       mdr,            exp_mdr);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 0; if_req = 0; if_pc = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        d3_req = 0; d3_we = 0; d3_addr = 0; d3_wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1;
        @(negedge clk);

        // Aligned fetch at 128
        if_req = 1; if_pc = 32'd128;
        @(negedge clk);
        chk("f1_mem_addr", mem_addr, 32'd128);
        chk("f1_ack_early", 32'(if_ack), 32'd0);
        @(negedge clk);
        chk("f1_if_ack", 32'(if_ack), 32'd1);
        chk("f1_ir", ir, 32'h8c03_0000);
        chk("f1_mem_write", 32'(mem_write), 32'd0);
        if_req = 0;
        @(negedge clk);
        chk("f1_idle", 32'(busy), 32'd0);

        // Data write 13 -> 6
        d_req = 1; d_we = 1; d_addr = 32'd6; d_wdata = 32'd13;
        @(negedge clk);
        chk("w_mem_write", 32'(mem_write), 32'd1);
        chk("w_mem_addr", mem_addr, 32'd6);
        chk("w_mem_wdata", mem_wdata, 32'd13);
        @(negedge clk);
        chk("w_d_ack", 32'(d_ack), 32'd1);
        chk("w_mem_write_off", 32'(mem_write), 32'd0);
        chk("w_mdr_kept", mdr, 32'd0);
        d_req = 0; d_we = 0;
        @(negedge clk);

        // Simultaneous fetch (132) and data read (0): data first
        if_req = 1; if_pc = 32'd132; d_req = 1; d_addr = 32'd0;
        @(negedge clk);
        chk("c_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("c_d_ack", 32'(d_ack), 32'd1);
        chk("c_if_ack_low", 32'(if_ack), 32'd0);
        chk("c_mdr", mdr, 32'd8);
        d_req = 0;
        @(negedge clk);
        chk("c_idle_reentry", 32'(busy), 32'd0);
        @(negedge clk);
        chk("c_fetch_addr", mem_addr, 32'd132);
        @(negedge clk);
        chk("c_if_ack", 32'(if_ack), 32'd1);
        chk("c_ir", ir, 32'h1000_0084);
        if_req = 0;
        @(negedge clk);

        // Read back the written word
        d_req = 1; d_addr = 32'd6;
        repeat (2) @(negedge clk);
        chk("rb_mdr", mdr, 32'd13);
        d_req = 0;
        @(negedge clk);

        // Fetch at misaligned 130
        if_req = 1; if_pc = 32'd130;
        @(negedge clk);
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_if_ack", 32'(if_ack), 32'd1);
        chk("mis_err", 32'(err), 32'd1);
        chk("mis_mem_addr", mem_addr, 32'd0);
        chk("mis_ir_kept", ir, 32'h1000_0084);
        if_req = 0;
        @(negedge clk);
`else
        chk("mis_mem_addr", mem_addr, 32'd130);
        chk("mis_ack_early", 32'(if_ack), 32'd0);
        @(negedge clk);
        chk("mis_if_ack", 32'(if_ack), 32'd1);
        chk("mis_err", 32'(err), 32'd0);
        chk("mis_ir", ir, 32'hdead_beef);
        if_req = 0;
`endif
        @(negedge clk);

        // Reset in the middle of a write
        d_req = 1; d_we = 1; d_addr = 32'd7; d_wdata = 32'd99;
        @(negedge clk);
        chk("rw_mem_write", 32'(mem_write), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("rw_mem_write_off", 32'(mem_write), 32'd0);
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_mem_addr", mem_addr, 32'd0);
        d_req = 0; d_we = 0;
        @(negedge clk);
        chk("rw_no_ack", 32'(d_ack), 32'd0);
        chk("rw_ir_clr", ir, 32'd0);
        rst_n = 1;
        @(negedge clk);
        d_req = 1; d_addr = 32'd7;
        repeat (2) @(negedge clk);
        chk("rw_abandoned", mdr, 32'h1000_0007);
        d_req = 0;
        @(negedge clk);

        // LATENCY=3 read of address 2
        d3_req = 1; d3_addr = 32'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("l3_mem_addr", mem3_addr, 32'd2);
            chk("l3_ack_early", 32'(d3_ack), 32'd0);
        end
        @(negedge clk);
        chk("l3_d_ack", 32'(d3_ack), 32'd1);
        chk("l3_mdr", mdr3, 32'hA5A5_0002);
        chk("l3_mem_addr_off", mem3_addr, 32'd0);
        d3_req = 0;
        @(negedge clk);
        chk("l3_idle", 32'(busy3), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning cycles the access is held on the memory port before capture (legal 1..15).
REQ-002 SHALL have port clk  input  1  the single system clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_req  input  1  instruction fetch request.
REQ-005 SHALL have port if_pc  input  32  fetch address.
REQ-006 SHALL have port if_ack  output  1  fetch complete, one-cycle pulse.
REQ-007 SHALL have port ir  output  32  instruction register.
REQ-008 SHALL have port d_req  input  1  data access request.
REQ-009 SHALL have port d_we  input  1  data access is a write (1) or read (0).
REQ-010 SHALL have port d_addr  input  32  data address.
REQ-011 SHALL have port d_wdata  input  32  data write value.
REQ-012 SHALL have port d_ack  output  1  data access complete, one-cycle pulse.
REQ-013 SHALL have port mdr  output  32  memory data register.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port err  output  1  misaligned fetch flag, pulses with if_ack.
REQ-016 SHALL have port mem_addr  output  32  address to unified memory, used unmodified as the word index.
REQ-017 SHALL have port mem_wdata  output  32  write data to memory.
REQ-018 SHALL have port mem_write  output  1  memory write strobe.
REQ-019 SHALL have port mem_rdata  input  32  combinational read data from memory.

Function
REQ-020 SHALL implement states IDLE, ACCESS, RESP; IDLE->ACCESS on accepted request; ACCESS->RESP when countdown reaches 0; RESP->IDLE unconditionally.
REQ-021 SHALL sample requests only in IDLE; d_req has priority over if_req when both are high; the loser stays pending.
REQ-022 SHALL latch address, write data and d_we on acceptance; input changes during ACCESS/RESP have no effect.
REQ-023 SHALL load countdown with LATENCY-1 on acceptance and decrement once per ACCESS cycle.
REQ-024 SHALL drive mem_addr/mem_wdata from latched values in ACCESS, and 0 in IDLE and RESP.
REQ-025 SHALL assert mem_write only in ACCESS cycles of a data write (exactly LATENCY cycles); never for fetches.
REQ-026 SHALL capture mem_rdata into ir (fetch) or mdr (data read) on the last ACCESS cycle; writes leave mdr unchanged.
REQ-027 SHALL pulse if_ack or d_ack for exactly one cycle in RESP; request accepted at edge N yields ack high during cycle N+LATENCY+1, with ir/mdr already valid.
REQ-028 SHALL hold ir and mdr until the next capture of the same type.
REQ-029 SHALL require requesters to drop req in the cycle ack is seen; a req still high in the following IDLE cycle starts a new access.

Reset
REQ-030 SHALL, while rst_n=0, force state IDLE, countdown 0, ir=0, mdr=0, if_ack=0, d_ack=0, err=0, busy=0, mem_write=0, mem_addr=0, mem_wdata=0 immediately, independent of clk.
REQ-031 SHALL abandon any access in progress on reset with no ack issued and no capture.

Configuration
REQ-032 SHALL, with macro MEM_ALIGN_CHECK_EN defined, treat an accepted fetch with if_pc[1:0]!=0 as misaligned: go directly IDLE->RESP, no memory access, ir unchanged, if_ack and err high together for one cycle.
REQ-033 SHALL, without MEM_ALIGN_CHECK_EN, perform all fetches normally and tie err to 0; data accesses are never alignment-checked.

Verification
REQ-034 Reset then if_req, if_pc=128, mem_rdata=32'h8c030000, LATENCY=1 -> if_ack 2 cycles after acceptance, ir=32'h8c030000, mem_write stays 0.
REQ-035 d_req, d_we=1, d_addr=6, d_wdata=13 -> mem_write=1 for exactly 1 cycle with mem_addr=6, mem_wdata=13; d_ack next cycle; mdr unchanged.
REQ-036 if_req (pc=132) and d_req read (addr=0, mem returns 8) same cycle -> d_ack first with mdr=8, then fetch served, if_ack 2 cycles after IDLE re-entry.
REQ-037 LATENCY=3, data read addr=2 -> mem_addr=2 for 3 cycles, d_ack 4 cycles after acceptance.
REQ-038 rst_n low during ACCESS of a write -> mem_write=0 immediately, no d_ack, busy=0.
REQ-039 MEM_ALIGN_CHECK_EN defined, if_pc=130 -> if_ack and err high next cycle, no mem_addr activity, ir unchanged; macro undefined -> normal 2-cycle fetch, err=0.
